// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use bubble, memory-busy freeze with watchdog, deferred branch flush; HAZARD_PERF_CNT_EN adds perf counters
module hazard_stall_ctrl #(
    parameter int unsigned MAX_MEM_WAIT = 15,
    parameter int unsigned WAIT_W = 4
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ID_EX_MemRead_i,
    input  logic [4:0] ID_EX_rd_i,
    input  logic [4:0] IF_ID_rs1_i,
    input  logic [4:0] IF_ID_rs2_i,
    input  logic       branch_taken_i,
    input  logic       mem_busy_i,
    output logic       NoOp_o,
    output logic       PCWrite_o,
    output logic       IF_ID_Stall_o,
    output logic       IF_ID_Flush_o,
    output logic       Freeze_o,
    output logic       timeout_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] lu_stall_cnt_o,
    output logic [CNT_W-1:0] freeze_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);
    typedef enum logic [1:0] {RUN, FREEZE, TIMEOUT} state_t;
    state_t state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic flush_pend_q, flush_pend_d;
    logic hazard, frz;
    assign hazard = ID_EX_MemRead_i & (ID_EX_rd_i != 5'd0) &
                    ((ID_EX_rd_i == IF_ID_rs1_i) | (ID_EX_rd_i == IF_ID_rs2_i));
    assign frz = ((state_q == FREEZE) | (state_q == RUN)) & mem_busy_i | (state_q == TIMEOUT);
    assign NoOp_o        = rst_i | (!frz & hazard);
    assign PCWrite_o     = !rst_i & !frz & !hazard;
    assign IF_ID_Stall_o = !rst_i & (frz | hazard);
    assign IF_ID_Flush_o = rst_i | (!frz & !hazard & (branch_taken_i | flush_pend_q));
    assign Freeze_o      = !rst_i & frz;
    assign timeout_o     = !rst_i & (state_q == TIMEOUT);
    always_comb begin
        state_d = state_q;
        wait_cnt_d = wait_cnt_q;
        // a branch seen while frozen is remembered; a load-use bubble keeps it pending
        flush_pend_d = frz ? (flush_pend_q | (!hazard & branch_taken_i)) : (hazard & flush_pend_q);
        case (state_q)
            RUN: begin
                state_d = mem_busy_i ? FREEZE : RUN;
                wait_cnt_d = mem_busy_i ? WAIT_W'(1) : '0;
            end
            FREEZE: begin
                state_d = !mem_busy_i ? RUN : (wait_cnt_q == WAIT_W'(MAX_MEM_WAIT)) ? TIMEOUT : FREEZE;
                wait_cnt_d = !mem_busy_i ? '0 : (wait_cnt_q == WAIT_W'(MAX_MEM_WAIT)) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
            end
            default: ;
        endcase
        if (rst_i) begin
            state_d = RUN;
            wait_cnt_d = '0;
            flush_pend_d = 1'b0;
        end
    end
    always_ff @(posedge clk_i) begin
        state_q <= state_d;
        wait_cnt_q <= wait_cnt_d;
        flush_pend_q <= flush_pend_d;
    end
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d, frz_cnt_q, frz_cnt_d, fl_cnt_q, fl_cnt_d;
    always_comb begin
        lu_cnt_d  = rst_i ? '0 : lu_cnt_q  + CNT_W'(NoOp_o & ~&lu_cnt_q);
        frz_cnt_d = rst_i ? '0 : frz_cnt_q + CNT_W'(Freeze_o & ~&frz_cnt_q);
        fl_cnt_d  = rst_i ? '0 : fl_cnt_q  + CNT_W'(IF_ID_Flush_o & ~&fl_cnt_q);
    end
    always_ff @(posedge clk_i) begin
        lu_cnt_q <= lu_cnt_d;
        frz_cnt_q <= frz_cnt_d;
        fl_cnt_q <= fl_cnt_d;
    end
    assign lu_stall_cnt_o = lu_cnt_q;
    assign freeze_cnt_o = frz_cnt_q;
    assign flush_cnt_o = fl_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed vector table plus watchdog/reset sequences for hazard_stall_ctrl
module tb_hazard_stall_ctrl;
    logic clk = 1'b0, rst, mr, br, busy;
    logic [4:0] rd, rs1, rs2;
    logic noop, pcw, stall, flush, frz, tmo;
    int checks = 0, errors = 0;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lu_cnt, frz_cnt, fl_cnt;
`endif
    always #5 clk = ~clk;
    hazard_stall_ctrl dut (
        .clk_i(clk), .rst_i(rst), .ID_EX_MemRead_i(mr), .ID_EX_rd_i(rd),
        .IF_ID_rs1_i(rs1), .IF_ID_rs2_i(rs2), .branch_taken_i(br), .mem_busy_i(busy),
        .NoOp_o(noop), .PCWrite_o(pcw), .IF_ID_Stall_o(stall), .IF_ID_Flush_o(flush),
        .Freeze_o(frz), .timeout_o(tmo)
`ifdef HAZARD_PERF_CNT_EN
        , .lu_stall_cnt_o(lu_cnt), .freeze_cnt_o(frz_cnt), .flush_cnt_o(fl_cnt)
`endif
    );
    typedef struct {
        logic rst, mr;
        logic [4:0] rd, rs1, rs2;
        logic br, busy;
        logic [5:0] exp;
    } vec_t;
    localparam logic [5:0] RST = 6'b100100, IDLE = 6'b010000, LU = 6'b101000,
                           FLU = 6'b010100, FRZ = 6'b001010, TMO = 6'b001011;
    vec_t v [24];
    task automatic cyc(input string nm, input logic r, input logic m, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic b, input logic bz,
                       input logic [5:0] exp);
        logic [5:0] got;
        rst = r; mr = m; rd = d; rs1 = s1; rs2 = s2; br = b; busy = bz;
        #2;
        got = {noop, pcw, stall, flush, frz, tmo};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got {noop,pcw,stall,flush,frz,tmo}=%b expected %b", nm, got, exp);
        end
        @(posedge clk);
        #1;
    endtask
    initial begin
        v[0]  = '{1, 0, 0, 0, 0, 0, 0, RST};
        v[1]  = '{0, 0, 0, 0, 0, 0, 0, IDLE};
        v[2]  = '{0, 1, 5, 5, 0, 0, 0, LU};
        v[3]  = '{0, 0, 5, 5, 0, 0, 0, IDLE};
        v[4]  = '{0, 1, 0, 0, 0, 0, 0, IDLE};
        v[5]  = '{0, 1, 7, 3, 4, 0, 0, IDLE};
        v[6]  = '{0, 1, 9, 1, 9, 0, 0, LU};
        v[7]  = '{0, 1, 5, 5, 0, 1, 0, LU};
        v[8]  = '{0, 0, 0, 0, 0, 1, 0, FLU};
        v[9]  = '{0, 1, 5, 5, 0, 0, 1, FRZ};
        v[10] = '{0, 1, 5, 5, 0, 0, 0, LU};
        v[11] = '{0, 0, 0, 0, 0, 0, 0, IDLE};
        v[12] = '{0, 0, 0, 0, 0, 0, 1, FRZ};
        v[13] = '{0, 0, 0, 0, 0, 1, 1, FRZ};
        v[14] = '{0, 0, 0, 0, 0, 0, 1, FRZ};
        v[15] = '{0, 0, 0, 0, 0, 0, 0, FLU};
        v[16] = '{0, 0, 0, 0, 0, 0, 0, IDLE};
        v[17] = '{0, 0, 0, 0, 0, 1, 1, FRZ};
        v[18] = '{0, 0, 0, 0, 0, 1, 0, FLU};
        v[19] = '{0, 0, 0, 0, 0, 0, 0, IDLE};
        v[20] = '{0, 0, 0, 0, 0, 1, 1, FRZ};
        v[21] = '{0, 1, 5, 0, 5, 0, 0, LU};
        v[22] = '{0, 0, 0, 0, 0, 0, 0, FLU};
        v[23] = '{0, 0, 0, 0, 0, 0, 0, IDLE};
        rst = 1; mr = 0; rd = 0; rs1 = 0; rs2 = 0; br = 0; busy = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 24; i++)
            cyc($sformatf("vec%0d", i), v[i].rst, v[i].mr, v[i].rd, v[i].rs1, v[i].rs2, v[i].br, v[i].busy, v[i].exp);
        // 15 busy cycles then release: no timeout
        for (int i = 1; i <= 15; i++) cyc($sformatf("busy15_c%0d", i), 0, 0, 0, 0, 0, 0, 1, FRZ);
        cyc("busy15_release", 0, 0, 0, 0, 0, 0, 0, IDLE);
        // watchdog: 16 frozen cycles, 17th is TIMEOUT
        for (int i = 1; i <= 16; i++) cyc($sformatf("wd_c%0d", i), 0, 0, 0, 0, 0, 0, 1, FRZ);
        cyc("wd_c17", 0, 0, 0, 0, 0, 0, 1, TMO);
        cyc("wd_sticky1", 0, 1, 5, 5, 0, 1, 0, TMO);
        cyc("wd_sticky2", 0, 0, 0, 0, 0, 0, 0, TMO);
        cyc("wd_reset", 1, 0, 0, 0, 0, 0, 0, RST);
        cyc("wd_after_reset", 0, 0, 0, 0, 0, 0, 0, IDLE);
        // reset mid-freeze, then the wait count restarts from 1
        for (int i = 1; i <= 5; i++) cyc($sformatf("mid_c%0d", i), 0, 0, 0, 0, 0, 0, 1, FRZ);
        cyc("mid_reset", 1, 0, 0, 0, 0, 0, 1, RST);
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if ({lu_cnt, frz_cnt, fl_cnt} !== 96'd0) begin
            errors++;
            $display("FAIL perf_after_reset got %0d %0d %0d expected 0 0 0", lu_cnt, frz_cnt, fl_cnt);
        end
`endif
        for (int i = 1; i <= 16; i++) cyc($sformatf("post_c%0d", i), 0, 0, 0, 0, 0, 0, 1, FRZ);
        cyc("post_c17", 0, 0, 0, 0, 0, 0, 1, TMO);
        cyc("final_reset", 1, 0, 0, 0, 0, 0, 0, RST);
        cyc("final_idle", 0, 0, 0, 0, 0, 0, 0, IDLE);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Control-side counterpart of the ID/EX pipeline register in the 5-stage RV32 core.
- Sits between the ID stage and the pipeline registers. It produces the NoOp (bubble) input for ID/EX, the PC write enable, and the IF/ID stall and flush signals.
- Detects load-use hazards from the ID/EX outputs.
- Freezes the whole pipeline while data memory reports busy, with a watchdog on that wait.
- Defers a taken-branch flush that arrives during a freeze.

Parameters:
- MAX_MEM_WAIT, 15: maximum consecutive mem_busy_i cycles tolerated in FREEZE before entering TIMEOUT.
- WAIT_W, 4: width of the wait counter. Must satisfy 2^WAIT_W > MAX_MEM_WAIT.
- CNT_W, 32: width of the performance counters (optional feature only).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- ID_EX_MemRead_i  in  1  MemRead output of ID/EX.
- ID_EX_rd_i  in  5  rd output of ID/EX.
- IF_ID_rs1_i  in  5  rs1 field of the instruction in ID.
- IF_ID_rs2_i  in  5  rs2 field of the instruction in ID.
- branch_taken_i  in  1  ID-stage branch resolved taken.
- mem_busy_i  in  1  data memory cannot complete this cycle.
- NoOp_o  out  1  to ID/EX NoOp_i; forces the control fields to 0.
- PCWrite_o  out  1  PC update enable.
- IF_ID_Stall_o  out  1  IF/ID hold.
- IF_ID_Flush_o  out  1  IF/ID clear to NOP.
- Freeze_o  out  1  hold all pipeline registers and the PC.
- timeout_o  out  1  sticky memory-wait watchdog error.

Behaviour:
- Internal terms:
  - hazard = ID_EX_MemRead_i & (ID_EX_rd_i != 0) & (ID_EX_rd_i == IF_ID_rs1_i | ID_EX_rd_i == IF_ID_rs2_i).
  - frz = (state==FREEZE | state==RUN) & mem_busy_i | state==TIMEOUT.
- State is {state, wait_cnt[WAIT_W-1:0], flush_pend}. Outputs are combinational from state and current inputs.
- While rst_i=1: NoOp_o=1, PCWrite_o=0, IF_ID_Stall_o=0, IF_ID_Flush_o=1, Freeze_o=0, timeout_o=0.
  - Next state: RUN, wait_cnt=0, flush_pend=0.
  - Reset in any state, including TIMEOUT or mid-FREEZE, returns to RUN the next cycle.
- Priority when not in reset: frz > hazard > branch.
- frz=1:
  - Freeze_o=1, PCWrite_o=0, IF_ID_Stall_o=1, NoOp_o=0, IF_ID_Flush_o=0.
- frz=0 and hazard=1 (load-use):
  - NoOp_o=1, PCWrite_o=0, IF_ID_Stall_o=1, IF_ID_Flush_o=0.
  - branch_taken_i is ignored because its operands are not valid yet.
  - Exactly one bubble per load-use pair: next cycle ID/EX holds the bubble (MemRead=0), so hazard drops.
- frz=0, hazard=0:
  - PCWrite_o=1, NoOp_o=0, IF_ID_Stall_o=0.
  - IF_ID_Flush_o = branch_taken_i | flush_pend.
  - flush_pend clears this cycle. Only one flush is issued even if both terms are 1.
- flush_pend is set on any cycle with frz=1, hazard=0, branch_taken_i=1.
- FSM:
  - RUN:
    - mem_busy_i=1 -> FREEZE, wait_cnt<=1.
    - Otherwise stay in RUN, wait_cnt=0.
  - FREEZE:
    - mem_busy_i=0 -> RUN, wait_cnt<=0. Freeze_o=0 in that same cycle.
    - mem_busy_i=1 and wait_cnt==MAX_MEM_WAIT -> TIMEOUT.
    - Otherwise wait_cnt<=wait_cnt+1. The counter never wraps.
  - TIMEOUT:
    - timeout_o=1 and Freeze_o=1 permanently until rst_i.
    - mem_busy_i is ignored.
- Freeze latency is 0 cycles: same-cycle response to mem_busy_i.
- Total frozen cycles before TIMEOUT = MAX_MEM_WAIT+1. The (MAX_MEM_WAIT+2)th consecutive busy cycle is the first in TIMEOUT.
- rd=x0 never causes a stall.
- hazard during frz produces no bubble; the stall is re-evaluated after the freeze ends.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds outputs lu_stall_cnt_o, freeze_cnt_o and flush_cnt_o, each out CNT_W.
  - They count, respectively, cycles with a load-use bubble, cycles with Freeze_o=1, and cycles with IF_ID_Flush_o=1 outside reset.
  - Each counter saturates at all-ones and is cleared by rst_i.
- Undefined: these ports and their registers do not exist. All other behaviour is identical.

Test Plan:
- Load-use: ID_EX_MemRead_i=1, rd=5, rs1=5, one cycle, then MemRead=0 -> that cycle NoOp_o=1, PCWrite_o=0, IF_ID_Stall_o=1; next cycle PCWrite_o=1, NoOp_o=0.
- x0 and no-match: MemRead=1, rd=0, rs2=0 -> no stall; rd=7, rs1=3, rs2=4 -> no stall.
- Freeze release: mem_busy_i high 3 cycles -> Freeze_o=1 for exactly those 3 cycles, state back to RUN, timeout_o=0. Assert branch_taken_i on frozen cycle 2 and drop it before release -> single IF_ID_Flush_o pulse on the first unfrozen cycle.
- Watchdog: MAX_MEM_WAIT=15, mem_busy_i held 17 cycles -> timeout_o rises on cycle 17 and stays 1 after mem_busy_i drops; rst_i for 1 cycle -> timeout_o=0, RUN.
- Priority: load-use hazard together with branch_taken_i=1 -> IF_ID_Flush_o=0, NoOp_o=1. Hazard together with mem_busy_i=1 -> NoOp_o=0, Freeze_o=1.
- Reset mid-freeze: mem_busy_i=1 for 5 cycles, then rst_i=1 -> NoOp_o=1, IF_ID_Flush_o=1, Freeze_o=0 during reset; after reset with mem_busy_i=1, wait_cnt restarts at 1. With HAZARD_PERF_CNT_EN defined, counters read 0 after reset.
